rvfi_retire_buffer: RTL and testbench

//  Parametrised RVFI trace generator for the Sodor cores. Captures one retired instruction
//  per cycle, decodes operand/dest fields, derives RVFI memory masks, tags a 64-bit order

---
 rtl/rvfi_retire_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_rvfi_retire_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_buffer.sv
// rtl/rvfi_retire_buffer.sv - RVFI retire capture, decode, order tagging and NRET-lane drain FIFO
//
// Captures one retired instruction per clock, decodes the RVFI register and memory
// fields, tags each record with a 64-bit order number and queues it. Each cycle up to
// NRET records are drained onto the RVFI lanes when the checker is ready.
// Assumes XLEN >= 32 and DEPTH a power of two >= 2 with DEPTH >= NRET.
//
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   retire, trap, instruction      retire tap: instruction retires / trapped / word
//   rs1_rdata, rs2_rdata, rd_wdata register file values
//   old_pc, new_pc                 pc of the instruction and next pc
//   mem_req, mem_we, mem_be        data access valid / store / {unsigned, size[1:0]}
//   mem_addr, mem_rdata, mem_wdata data access address and data
//   trace_ready                    checker accepts lanes in the next cycle
//   rvfi_*                         NRET-lane RVFI bus, lane i in bits [i*W +: W]
//   occupancy                      records currently held
//   overflow                       sticky: a retire was dropped because the queue was full
module rvfi_retire_buffer #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          retire,
  input  logic                          trap,
  input  logic [ILEN-1:0]               instruction,
  input  logic [XLEN-1:0]               rs1_rdata,
  input  logic [XLEN-1:0]               rs2_rdata,
  input  logic [XLEN-1:0]               rd_wdata,
  input  logic [XLEN-1:0]               old_pc,
  input  logic [XLEN-1:0]               new_pc,
  input  logic                          mem_req,
  input  logic                          mem_we,
  input  logic [2:0]                    mem_be,
  input  logic [XLEN-1:0]               mem_addr,
  input  logic [XLEN-1:0]               mem_rdata,
  input  logic [XLEN-1:0]               mem_wdata,
  input  logic                          trace_ready,
  output logic [NRET-1:0]               rvfi_valid,
  output logic [NRET*64-1:0]            rvfi_order,
  output logic [NRET*ILEN-1:0]          rvfi_insn,
  output logic [NRET-1:0]               rvfi_trap,
  output logic [NRET*5-1:0]             rvfi_rs1_addr,
  output logic [NRET*5-1:0]             rvfi_rs2_addr,
  output logic [NRET*5-1:0]             rvfi_rd_addr,
  output logic [NRET*XLEN-1:0]          rvfi_rs1_rdata,
  output logic [NRET*XLEN-1:0]          rvfi_rs2_rdata,
  output logic [NRET*XLEN-1:0]          rvfi_rd_wdata,
  output logic [NRET*XLEN-1:0]          rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0]          rvfi_pc_wdata,
  output logic [NRET*XLEN-1:0]          rvfi_mem_addr,
  output logic [NRET*XLEN-1:0]          rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0]          rvfi_mem_wdata,
  output logic [NRET*(XLEN/8)-1:0]      rvfi_mem_rmask,
  output logic [NRET*(XLEN/8)-1:0]      rvfi_mem_wmask,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic                          overflow
);
  localparam int MW = XLEN / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [63:0]     order;
    logic [ILEN-1:0] insn;
    logic            trap;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [MW-1:0]   rmask;
    logic [MW-1:0]   wmask;
  } rec_t;

  rec_t            fifo [DEPTH];
  rec_t            cap;
  rec_t            lane_q [NRET];
  logic [NRET-1:0] valid_q;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [OW-1:0]   occ, pops;
  logic [63:0]     order_cnt;
  logic            push_ok;
  logic [6:0]      opcode;
  logic [MW-1:0]   size_mask;
  logic [XLEN-1:0] byte_mask;

  // Loaded data is already masked to the access size, so the unsigned flag changes nothing.
  logic unused_mem_be2;
  assign unused_mem_be2 = mem_be[2];

  // Record decode for the instruction retiring this cycle.
  always_comb begin
    opcode    = instruction[6:0];
    size_mask = '0;
    case (mem_be[1:0])
      2'b01:   size_mask[0]   = 1'b1;
      2'b10:   size_mask[1:0] = 2'b11;
      2'b11:   size_mask[3:0] = 4'hf;
      default: ;
    endcase
    byte_mask = '0;
    for (int b = 0; b < MW; b++) byte_mask[b*8 +: 8] = {8{size_mask[b]}};

    cap          = '0;
    cap.order    = order_cnt;
    cap.insn     = instruction;
    cap.trap     = trap;
    cap.pc_rdata = old_pc;
    cap.pc_wdata = new_pc;
    cap.rs1_addr = (opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL)
                   ? 5'd0 : instruction[19:15];
    cap.rs2_addr = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH)
                   ? instruction[24:20] : 5'd0;
    cap.rd_addr  = (opcode == OPC_STORE || opcode == OPC_BRANCH) ? 5'd0 : instruction[11:7];

    if (mem_req && mem_be[1:0] != 2'b00) begin
      cap.mem_addr = mem_addr;
      if (mem_we) begin
        cap.wmask     = size_mask;
        cap.mem_wdata = mem_wdata & byte_mask;
      end else begin
        cap.rmask     = size_mask;
        cap.mem_rdata = mem_rdata & byte_mask;
      end
    end

    // A trapped instruction commits no register or memory side effects.
    if (trap) begin
      cap.rd_addr   = 5'd0;
      cap.rmask     = '0;
      cap.wmask     = '0;
      cap.mem_rdata = '0;
      cap.mem_wdata = '0;
    end

    cap.rs1_rdata = (cap.rs1_addr != 5'd0) ? rs1_rdata : '0;
    cap.rs2_rdata = (cap.rs2_addr != 5'd0) ? rs2_rdata : '0;
    cap.rd_wdata  = (cap.rd_addr  != 5'd0) ? rd_wdata  : '0;
  end

  // Pops are decided from pre-edge occupancy; a same-cycle pop frees room for the push.
  always_comb begin
    if (!trace_ready)            pops = '0;
    else if (occ < OW'(NRET))    pops = occ;
    else                         pops = OW'(NRET);
    push_ok = retire && ((occ - pops) < OW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo[wr_ptr] <= cap;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      order_cnt <= '0;
      overflow  <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < NRET; i++) lane_q[i] <= '0;
    end else begin
      // Dropped retires still consume an order number so the gap is visible downstream.
      if (retire)            order_cnt <= order_cnt + 64'd1;
      if (retire && !push_ok) overflow <= 1'b1;
      if (push_ok)           wr_ptr    <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pops);
      occ    <= occ - pops + OW'(push_ok);
      for (int i = 0; i < NRET; i++) begin
        if (OW'(i) < pops) begin
          valid_q[i] <= 1'b1;
          lane_q[i]  <= fifo[rd_ptr + AW'(i)];
        end else begin
          valid_q[i] <= 1'b0;
          lane_q[i]  <= '0;
        end
      end
    end
  end

  assign rvfi_valid = valid_q;
  assign occupancy  = occ;

  for (genvar i = 0; i < NRET; i++) begin : g_lane
    assign rvfi_order[i*64 +: 64]        = lane_q[i].order;
    assign rvfi_insn[i*ILEN +: ILEN]     = lane_q[i].insn;
    assign rvfi_trap[i]                  = lane_q[i].trap;
    assign rvfi_rs1_addr[i*5 +: 5]       = lane_q[i].rs1_addr;
    assign rvfi_rs2_addr[i*5 +: 5]       = lane_q[i].rs2_addr;
    assign rvfi_rd_addr[i*5 +: 5]        = lane_q[i].rd_addr;
    assign rvfi_rs1_rdata[i*XLEN +: XLEN] = lane_q[i].rs1_rdata;
    assign rvfi_rs2_rdata[i*XLEN +: XLEN] = lane_q[i].rs2_rdata;
    assign rvfi_rd_wdata[i*XLEN +: XLEN]  = lane_q[i].rd_wdata;
    assign rvfi_pc_rdata[i*XLEN +: XLEN]  = lane_q[i].pc_rdata;
    assign rvfi_pc_wdata[i*XLEN +: XLEN]  = lane_q[i].pc_wdata;
    assign rvfi_mem_addr[i*XLEN +: XLEN]  = lane_q[i].mem_addr;
    assign rvfi_mem_rdata[i*XLEN +: XLEN] = lane_q[i].mem_rdata;
    assign rvfi_mem_wdata[i*XLEN +: XLEN] = lane_q[i].mem_wdata;
    assign rvfi_mem_rmask[i*MW +: MW]     = lane_q[i].rmask;
    assign rvfi_mem_wmask[i*MW +: MW]     = lane_q[i].wmask;
  end

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// tb/tb_rvfi_retire_buffer.sv - self-checking bench for rvfi_retire_buffer against a queue model
module tb_rvfi_retire_buffer;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;
  localparam int MW    = XLEN / 8;
  localparam int OW    = $clog2(DEPTH + 1);

  logic clock = 1'b0;
  logic reset_n, retire, trap, mem_req, mem_we, trace_ready;
  logic [ILEN-1:0] instruction;
  logic [XLEN-1:0] rs1_rdata, rs2_rdata, rd_wdata, old_pc, new_pc;
  logic [XLEN-1:0] mem_addr, mem_rdata, mem_wdata;
  logic [2:0] mem_be;
  logic [NRET-1:0] rvfi_valid, rvfi_trap;
  logic [NRET*64-1:0] rvfi_order;
  logic [NRET*ILEN-1:0] rvfi_insn;
  logic [NRET*5-1:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [NRET*XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [NRET*XLEN-1:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [NRET*MW-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
  logic [OW-1:0] occupancy;
  logic overflow;

  always #5 clock = ~clock;

  rvfi_retire_buffer #(.XLEN(XLEN), .ILEN(ILEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .retire(retire), .trap(trap), .instruction(instruction),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .rd_wdata(rd_wdata),
    .old_pc(old_pc), .new_pc(new_pc), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .trace_ready(trace_ready),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .occupancy(occupancy), .overflow(overflow)
  );

  typedef struct {
    logic [63:0] order; logic [ILEN-1:0] insn; logic trap;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] rs1d, rs2d, rdd, pcr, pcw, maddr, mrd, mwd;
    logic [MW-1:0] rmask, wmask;
  } exp_t;

  exp_t q[$];
  exp_t el[NRET];
  logic ev[NRET];
  logic [63:0] m_order;
  logic m_ovf;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected record straight from the capture rules, using the currently driven inputs.
  function automatic exp_t ref_rec();
    exp_t e;
    logic [6:0] op;
    int nbytes;
    logic [XLEN-1:0] bm;
    op = instruction[6:0];
    e.order = m_order; e.insn = instruction; e.trap = trap;
    e.pcr = old_pc; e.pcw = new_pc;
    e.rs1 = (op == 7'h37 || op == 7'h17 || op == 7'h6f) ? 5'd0 : instruction[19:15];
    e.rs2 = (op == 7'h33 || op == 7'h23 || op == 7'h63) ? instruction[24:20] : 5'd0;
    e.rd  = (op == 7'h23 || op == 7'h63) ? 5'd0 : instruction[11:7];
    e.maddr = '0; e.mrd = '0; e.mwd = '0; e.rmask = '0; e.wmask = '0;
    nbytes = 0;
    if (mem_req) nbytes = (mem_be[1:0] == 2'd1) ? 1 : (mem_be[1:0] == 2'd2) ? 2 : (mem_be[1:0] == 2'd3) ? 4 : 0;
    if (nbytes != 0) begin
      bm = XLEN'((64'd1 << (8 * nbytes)) - 64'd1);
      e.maddr = mem_addr;
      if (mem_we) begin e.wmask = MW'((1 << nbytes) - 1); e.mwd = mem_wdata & bm; end
      else        begin e.rmask = MW'((1 << nbytes) - 1); e.mrd = mem_rdata & bm; end
    end
    if (trap) begin e.rd = 0; e.rmask = 0; e.wmask = 0; e.mrd = 0; e.mwd = 0; end
    e.rs1d = (e.rs1 == 0) ? '0 : rs1_rdata;
    e.rs2d = (e.rs2 == 0) ? '0 : rs2_rdata;
    e.rdd  = (e.rd == 0)  ? '0 : rd_wdata;
    return e;
  endfunction

  task automatic check_all();
    logic [NRET-1:0] xv, xt;
    logic [NRET*64-1:0] xo;
    logic [NRET*ILEN-1:0] xi;
    logic [NRET*5-1:0] x1, x2, xd;
    logic [NRET*XLEN-1:0] x1d, x2d, xdd, xpr, xpw, xma, xmr, xmw;
    logic [NRET*MW-1:0] xrm, xwm;
    {xv, xt, xo, xi, x1, x2, xd} = '0;
    {x1d, x2d, xdd, xpr, xpw, xma, xmr, xmw, xrm, xwm} = '0;
    for (int i = 0; i < NRET; i++) begin
      if (ev[i]) begin
        xv[i] = 1'b1; xt[i] = el[i].trap; xo[i*64 +: 64] = el[i].order;
        xi[i*ILEN +: ILEN] = el[i].insn;
        x1[i*5 +: 5] = el[i].rs1; x2[i*5 +: 5] = el[i].rs2; xd[i*5 +: 5] = el[i].rd;
        x1d[i*XLEN +: XLEN] = el[i].rs1d; x2d[i*XLEN +: XLEN] = el[i].rs2d;
        xdd[i*XLEN +: XLEN] = el[i].rdd;  xpr[i*XLEN +: XLEN] = el[i].pcr;
        xpw[i*XLEN +: XLEN] = el[i].pcw;  xma[i*XLEN +: XLEN] = el[i].maddr;
        xmr[i*XLEN +: XLEN] = el[i].mrd;  xmw[i*XLEN +: XLEN] = el[i].mwd;
        xrm[i*MW +: MW] = el[i].rmask;    xwm[i*MW +: MW] = el[i].wmask;
      end
    end
    chk("valid", rvfi_valid, xv);          chk("order", rvfi_order, xo);
    chk("insn", rvfi_insn, xi);            chk("trap", rvfi_trap, xt);
    chk("rs1_addr", rvfi_rs1_addr, x1);    chk("rs2_addr", rvfi_rs2_addr, x2);
    chk("rd_addr", rvfi_rd_addr, xd);      chk("rs1_rdata", rvfi_rs1_rdata, x1d);
    chk("rs2_rdata", rvfi_rs2_rdata, x2d); chk("rd_wdata", rvfi_rd_wdata, xdd);
    chk("pc_rdata", rvfi_pc_rdata, xpr);   chk("pc_wdata", rvfi_pc_wdata, xpw);
    chk("mem_addr", rvfi_mem_addr, xma);   chk("mem_rdata", rvfi_mem_rdata, xmr);
    chk("mem_wdata", rvfi_mem_wdata, xmw); chk("mem_rmask", rvfi_mem_rmask, xrm);
    chk("mem_wmask", rvfi_mem_wmask, xwm);
    chk("occupancy", occupancy, q.size()); chk("overflow", overflow, m_ovf);
  endtask

  // One clock: model the edge, then sample 1 time unit after it.
  task automatic step();
    int np;
    np = trace_ready ? ((q.size() < NRET) ? q.size() : NRET) : 0;
    for (int i = 0; i < NRET; i++) begin
      ev[i] = (i < np);
      if (i < np) el[i] = q.pop_front();
    end
    if (retire) begin
      if (q.size() < DEPTH) q.push_back(ref_rec());
      else m_ovf = 1'b1;
      m_order++;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    retire = 0; trap = 0; instruction = '0; rs1_rdata = '0; rs2_rdata = '0; rd_wdata = '0;
    old_pc = '0; new_pc = '0; mem_req = 0; mem_we = 0; mem_be = '0;
    mem_addr = '0; mem_rdata = '0; mem_wdata = '0;
  endtask

  task automatic rand_retire();
    logic [6:0] ops[9];
    ops = '{7'h37, 7'h17, 7'h6f, 7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67};
    retire = 1;
    trap = ($urandom_range(0, 9) == 0);
    instruction = {$urandom()} & 32'hffff_ff80;
    instruction[6:0] = ops[$urandom_range(0, 8)];
    rs1_rdata = $urandom(); rs2_rdata = $urandom(); rd_wdata = $urandom();
    old_pc = $urandom(); new_pc = $urandom();
    mem_req = $urandom_range(0, 1); mem_we = $urandom_range(0, 1); mem_be = 3'($urandom_range(0, 7));
    mem_addr = $urandom(); mem_rdata = $urandom(); mem_wdata = $urandom();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for the clock.
  task automatic async_reset();
    #2 reset_n = 0;
    #1;
    q.delete(); m_order = '0; m_ovf = 1'b0;
    for (int i = 0; i < NRET; i++) ev[i] = 1'b0;
    check_all();
    set_idle();
    #3 reset_n = 1;
  endtask

  initial begin
    reset_n = 1; trace_ready = 0; set_idle();
    #1;
    async_reset();

    // ADDI x5,x1,3 with x1=7
    trace_ready = 1; retire = 1; instruction = 32'h0030_8293; rs1_rdata = 7; rd_wdata = 10;
    rs2_rdata = 32'h55; step();
    set_idle(); step();
    chk("addi_valid", rvfi_valid, 2'b01);
    chk("addi_order", rvfi_order[63:0], 0);
    chk("addi_rs1", rvfi_rs1_addr[4:0], 1);
    chk("addi_rs1_rdata", rvfi_rs1_rdata[31:0], 7);
    chk("addi_rs2", rvfi_rs2_addr[4:0], 0);
    chk("addi_rd", rvfi_rd_addr[4:0], 5);
    chk("addi_rd_wdata", rvfi_rd_wdata[31:0], 10);

    // SB then LHU back to back
    retire = 1; instruction = 32'h0031_0023; mem_req = 1; mem_we = 1; mem_be = 3'b001;
    mem_addr = 32'h100; mem_wdata = 32'haabb_ccdd; step();
    instruction = 32'h0001_5203; mem_we = 0; mem_be = 3'b110; mem_rdata = 32'h1234_5678;
    mem_wdata = '0; step();
    chk("sb_wmask", rvfi_mem_wmask[3:0], 4'b0001);
    chk("sb_wdata", rvfi_mem_wdata[31:0], 32'h0000_00dd);
    chk("sb_rmask", rvfi_mem_rmask[3:0], 4'b0000);
    set_idle(); step();
    chk("lhu_rmask", rvfi_mem_rmask[3:0], 4'b0011);
    chk("lhu_rdata", rvfi_mem_rdata[31:0], 32'h0000_5678);

    // Five retires held back, then drained 2,2,1
    trace_ready = 0;
    for (int i = 0; i < 5; i++) begin rand_retire(); step(); end
    set_idle(); trace_ready = 1;
    step(); chk("drain_a", rvfi_valid, 2'b11);
    step(); chk("drain_b", rvfi_valid, 2'b11);
    step(); chk("drain_c", rvfi_valid, 2'b01);

    // Full queue with a same-cycle pop still accepts the push
    async_reset();
    trace_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin rand_retire(); step(); end
    trace_ready = 1; rand_retire(); step();
    chk("full_pop_ovf", overflow, 1'b0);
    chk("full_pop_occ", occupancy, DEPTH - NRET + 1);

    // Overflow: ninth retire dropped, order gap visible
    async_reset();
    trace_ready = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin rand_retire(); step(); end
    chk("ovf_occ", occupancy, DEPTH);
    chk("ovf_flag", overflow, 1'b1);
    trace_ready = 1; rand_retire(); step();
    set_idle();
    for (int i = 0; i < 4; i++) step();
    chk("gap_order", rvfi_order[63:0], 64'd9);

    // Reset in the middle of a drain
    trace_ready = 0;
    for (int i = 0; i < 4; i++) begin rand_retire(); step(); end
    trace_ready = 1; set_idle(); step();
    async_reset();
    trace_ready = 1; rand_retire(); step();
    set_idle(); step();
    chk("post_reset_order", rvfi_order[63:0], 0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      trace_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 7) rand_retire(); else set_idle();
      step();
    end
    set_idle(); trace_ready = 1;
    for (int n = 0; n < 6; n++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
